// File: rtl/i2c_bus_pkg.sv
// Shared types and defaults for the I2C bus model.
package i2c_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  localparam logic [3:0] ACK_SLOT = 4'd8;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_CYCLES = 3;

endpackage

// File: rtl/i2c_sync_filter.sv
// Synchroniser followed by a stability filter: q follows d once the synchronised
// value has differed from q for FILT_CYCLES consecutive samples. Resets to 1.
module i2c_sync_filter
  import i2c_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic pclk,
  input  logic s_resetn,
  input  logic d,
  output logic q
);

  localparam int unsigned CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Counting only while s differs from q: any flip of s back to q's level
  // reloads the counter, so short glitches never reach q.
  always_ff @(posedge pclk) begin
    if (!s_resetn) begin
      sync <= '1;
      cnt  <= '0;
      q    <= 1'b1;
    end else begin
      sync[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      if (s == q) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_CYCLES - 1)) begin
        q   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_model.sv
// N-agent wired-AND I2C bus with filtered protocol tracking.
// Optional SCL-low timeout enabled by defining I2C_BUS_TIMEOUT_EN.
module i2c_bus_model
  import i2c_bus_pkg::*;
#(
  parameter int unsigned NUM_AGENTS     = 2,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned FILT_CYCLES    = DEF_FILT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  pclk,
  input  logic                  s_resetn,
  input  logic [NUM_AGENTS-1:0] scl_pad_o,
  input  logic [NUM_AGENTS-1:0] scl_padoen_o,
  input  logic [NUM_AGENTS-1:0] sda_pad_o,
  input  logic [NUM_AGENTS-1:0] sda_padoen_o,
  output logic [NUM_AGENTS-1:0] scl_pad_i,
  output logic [NUM_AGENTS-1:0] sda_pad_i,
  output logic                  scl_f,
  output logic                  sda_f,
  output logic                  start_det,
  output logic                  rstart_det,
  output logic                  stop_det,
  output logic                  bus_busy,
  output logic [3:0]            bit_cnt,
  output logic                  byte_done,
  output logic                  ack_bit,
  output logic [NUM_AGENTS-1:0] sda_mismatch,
  output logic                  contention,
  output logic                  timeout
);

  logic scl_drv_lo, scl_drv_hi, sda_drv_lo, sda_drv_hi;
  logic scl_bus, sda_bus;
  logic [NUM_AGENTS-1:0] sda_rel;

  always_comb begin
    scl_drv_lo = |(~scl_padoen_o & ~scl_pad_o);
    scl_drv_hi = |(~scl_padoen_o &  scl_pad_o);
    sda_drv_lo = |(~sda_padoen_o & ~sda_pad_o);
    sda_drv_hi = |(~sda_padoen_o &  sda_pad_o);
  end

  assign scl_bus    = ~scl_drv_lo;
  assign sda_bus    = ~sda_drv_lo;
  assign scl_pad_i  = {NUM_AGENTS{scl_bus}};
  assign sda_pad_i  = {NUM_AGENTS{sda_bus}};
  assign contention = (scl_drv_lo & scl_drv_hi) | (sda_drv_lo & sda_drv_hi);
  assign sda_rel    = sda_padoen_o | sda_pad_o;

  i2c_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_scl_filt (
    .pclk     (pclk),
    .s_resetn (s_resetn),
    .d        (scl_bus),
    .q        (scl_f)
  );

  i2c_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sda_filt (
    .pclk     (pclk),
    .s_resetn (s_resetn),
    .d        (sda_bus),
    .q        (sda_f)
  );

  bus_state_e            state_q, state_d;
  logic                  scl_q, sda_q;
  logic                  start_c, stop_c, scl_rise, to_hit;
  logic                  start_d, rstart_d, stop_d, byte_d, ack_d;
  logic [3:0]            bit_cnt_d;
  logic [NUM_AGENTS-1:0] mism_d;

  // Requiring SCL high both before and after excludes simultaneous SCL/SDA changes.
  assign start_c  = scl_q & scl_f & sda_q & ~sda_f;
  assign stop_c   = scl_q & scl_f & ~sda_q & sda_f;
  assign scl_rise = ~scl_q & scl_f;

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    rstart_d  = 1'b0;
    stop_d    = 1'b0;
    byte_d    = 1'b0;
    ack_d     = ack_bit;
    bit_cnt_d = bit_cnt;
    mism_d    = '0;
    if (start_c) begin
      state_d   = BUSY;
      bit_cnt_d = '0;
      if (state_q == BUSY) rstart_d = 1'b1;
      else                 start_d  = 1'b1;
    end else if (stop_c) begin
      state_d   = IDLE;
      stop_d    = 1'b1;
      bit_cnt_d = '0;
    end else if (to_hit) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (state_q == BUSY && scl_rise) begin
      if (bit_cnt == ACK_SLOT) begin
        byte_d    = 1'b1;
        ack_d     = sda_f;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt + 4'd1;
        if (!sda_f) mism_d = sda_rel;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!s_resetn) begin
      state_q      <= IDLE;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      start_det    <= 1'b0;
      rstart_det   <= 1'b0;
      stop_det     <= 1'b0;
      byte_done    <= 1'b0;
      ack_bit      <= 1'b1;
      bit_cnt      <= '0;
      sda_mismatch <= '0;
    end else begin
      state_q      <= state_d;
      scl_q        <= scl_f;
      sda_q        <= sda_f;
      start_det    <= start_d;
      rstart_det   <= rstart_d;
      stop_det     <= stop_d;
      byte_done    <= byte_d;
      ack_bit      <= ack_d;
      bit_cnt      <= bit_cnt_d;
      sda_mismatch <= mism_d;
    end
  end

  assign bus_busy = (state_q == BUSY);

`ifdef I2C_BUS_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        timeout_q;

  assign to_hit  = (state_q == BUSY) && !scl_f && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  always_ff @(posedge pclk) begin
    if (!s_resetn) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_hit;
      if ((state_q == BUSY) && !scl_f && !to_hit) to_cnt <= to_cnt + 32'd1;
      else                                        to_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_hit             = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: doc/i2c_bus_model.md
Name: i2c_bus_model

Overview:
- Parametrised N-agent I2C bus: wired-AND resolution of every agent's open-drain pad outputs onto shared SCL/SDA, fed back to all agents' pad inputs.
- Synchronises and glitch-filters the resolved bus, then tracks protocol state: START, repeated START, STOP, busy, bit/ACK slot, per-agent SDA mismatch.
- Sits between master/slave DUT instances and UVM agents in the I2C env; replaces point-to-point pad wiring.

Parameters:
- NUM_AGENTS, 2, number of attached pad drivers (>=1).
- SYNC_STAGES, 2, synchroniser depth for SCL and SDA (>=1).
- FILT_CYCLES, 3, consecutive stable pclk cycles before a filtered level changes (>=1).
- TIMEOUT_CYCLES, 1024, SCL-low timeout length. Used only with I2C_BUS_TIMEOUT_EN.

Ports:
- pclk  in  1  clock.
- s_resetn  in  1  synchronous active-low reset.
- scl_pad_o  in  NUM_AGENTS  per-agent SCL output value.
- scl_padoen_o  in  NUM_AGENTS  per-agent SCL output enable, active-low (0 = driving).
- sda_pad_o  in  NUM_AGENTS  per-agent SDA output value.
- sda_padoen_o  in  NUM_AGENTS  per-agent SDA output enable, active-low.
- scl_pad_i  out  NUM_AGENTS  resolved SCL replicated to every agent.
- sda_pad_i  out  NUM_AGENTS  resolved SDA replicated to every agent.
- scl_f, sda_f  out  1 each  synchronised and filtered bus levels.
- start_det, rstart_det, stop_det  out  1 each  single-cycle event pulses.
- bus_busy  out  1  high between START and STOP.
- bit_cnt  out  4  bit position in current byte, 0..8; 8 = ACK slot.
- byte_done  out  1  pulse on the SCL rise of the ACK slot.
- ack_bit  out  1  sda_f sampled at that rise (0 = ACK).
- sda_mismatch  out  NUM_AGENTS  pulse: agent released SDA but bus read 0 at SCL rise, outside ACK slot.
- contention  out  1  level: some agent drives 1 while another drives 0 on the same line.
- timeout  out  1  pulse on SCL-low timeout (0 when feature absent).

Behaviour:
- Resolution, combinational, zero latency:
  - A line is 0 if any agent has oen=0 and pad_o=0; otherwise 1 (pull-up).
  - Agent with oen=0 and pad_o=1 counts as driving high. This only affects contention.
  - scl_pad_i and sda_pad_i carry the raw resolved values.
- Synchroniser: SYNC_STAGES flops per line, reset to 1.
- Filter: counter reloads on every change of the synchronised value. Filtered output takes the new value after FILT_CYCLES consecutive equal samples. scl_f/sda_f reset to 1.
- Edge detection uses registered copies of scl_f/sda_f. Total input-to-event latency = SYNC_STAGES + FILT_CYCLES + 1 cycles.
- START: sda_f falls while scl_f is 1 before and after the change.
- STOP: sda_f rises under the same condition.
- scl_f and sda_f changing in the same cycle produces no event.
- FSM (states IDLE and BUSY), reset state IDLE:
  - IDLE to BUSY on START: pulse start_det.
  - BUSY to BUSY on START: pulse rstart_det only.
  - BUSY to IDLE on STOP: pulse stop_det.
  - STOP seen in IDLE: pulse stop_det, stay IDLE.
  - bus_busy = (state == BUSY).
- Bit counter:
  - Cleared to 0 on any START/rstart and on entering IDLE.
  - In BUSY, increments on each scl_f rise.
  - On the rise at bit_cnt == 8: pulse byte_done, latch ack_bit, wrap to 0.
- sda_mismatch[i]: on an scl_f rise in BUSY with bit_cnt != 8, asserted when agent i has released SDA (oen=1 or pad_o=1) and sda_f == 0.
- Reset values: all pulses 0, bus_busy 0, bit_cnt 0, ack_bit 1, scl_f/sda_f 1.
- Reset asserted mid-transfer returns to IDLE on the next pclk edge. No event is generated by the reset itself.

Optional Feature:
- Macro: I2C_BUS_TIMEOUT_EN.
- When defined: a 32-bit counter increments while state == BUSY and scl_f == 0, and clears otherwise. On reaching TIMEOUT_CYCLES it pulses timeout, forces IDLE, and clears bit_cnt.
- When undefined: no counter is built, and timeout is tied to 0.

Decomposition:
- Package i2c_bus_pkg holds:
  - bus_state_e enum {IDLE, BUSY};
  - ACK_SLOT = 4'd8;
  - the default values of the SYNC_STAGES/FILT_CYCLES parameters.
- Sub-module i2c_sync_filter (parameters SYNC_STAGES, FILT_CYCLES; ports pclk, s_resetn, d, q), instantiated once for SCL and once for SDA.

Test Plan:
- Reset and idle: s_resetn low 3 cycles, all agents oen=1 -> scl/sda_pad_i all 1, scl_f=1, bus_busy=0, bit_cnt=0, no pulses.
- Glitch rejection: with FILT_CYCLES=3, pulse agent0 SDA low for 2 cycles while SCL high -> no start_det. Hold low 3 cycles -> start_det exactly once, at SYNC_STAGES+FILT_CYCLES+1 = 6 cycles after the drop.
- Byte transfer: agent0 sends START, byte 0xA5, agent1 ACKs (SDA 0 in slot 9), STOP -> bit_cnt 0..8, byte_done with ack_bit=0, stop_det, bus_busy 1 to 0, sda_mismatch all 0.
- Repeated START and arbitration: START, 4 bits, START again -> rstart_det pulse, bit_cnt=0. Agent0 sends 1 while agent1 sends 0 on the same bit -> sda_mismatch[0] pulses, contention stays 0.
- Contention: agent0 oen=0,pad_o=1 and agent1 oen=0,pad_o=0 on SCL -> scl_pad_i=0, contention=1.
- Timeout (I2C_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): START then hold SCL low 16 cycles -> timeout pulse, bus_busy=0. Macro undefined -> timeout stays 0, bus stays busy.
